// File: rtl/nlf_pkg.sv
// Shared types and derived constants for the sequential fixed-point divider.
package nlf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DEF_W  = 16;
  localparam int DEF_BF = 8;

  // Numerator length: the dividend pre-shifted by the fractional bit count.
  function automatic int calc_n(input int w, input int bf);
    return w + bf;
  endfunction

  localparam int DEF_N = calc_n(DEF_W, DEF_BF);

endpackage

// File: rtl/fix_div_step.sv
// One restoring-division step: shift in the next numerator bit, compare, subtract.
module fix_div_step
  import nlf_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic         ge_o,
  output logic [W:0]   rem_o
);

  logic [W+1:0] r_shift;
  logic [W:0]   r_diff;

  always_comb begin
    r_shift = {rem_i, bit_i};
    ge_o    = (r_shift >= {2'b00, divisor_i});
    r_diff  = r_shift[W:0] - {1'b0, divisor_i};
    // The remainder stays below the divisor, so r' always fits in W+1 bits.
    rem_o   = ge_o ? r_diff : r_shift[W:0];
  end

endmodule

// File: rtl/fix_div_seq.sv
// Sequential restoring divider: quotient = floor((dividend << Bf) / divisor).
// Build option FIX_DIV_SAT_EN saturates the quotient to all-ones on overflow.
module fix_div_seq
  import nlf_pkg::*;
#(
  parameter int Bf              = DEF_BF,
  parameter int FIX_POINT_WIDTH = DEF_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIX_POINT_WIDTH-1:0] dividend,
  input  logic [FIX_POINT_WIDTH-1:0] divisor,
  output logic [FIX_POINT_WIDTH-1:0] add_in0,
  output logic [FIX_POINT_WIDTH-1:0] add_in1,
  output logic [FIX_POINT_WIDTH-1:0] add_u,
  output logic                       add_s_add,
  input  logic [FIX_POINT_WIDTH-1:0] add_out0,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIX_POINT_WIDTH-1:0] quotient,
  output logic                       ovf,
  output logic                       div_zero,
  output div_state_e                 dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE, and the result
  // holds until out_ready is seen.

  localparam int W  = FIX_POINT_WIDTH;
  localparam int N  = calc_n(W, Bf);
  localparam int CW = $clog2(N);

  div_state_e    state_q, state_d;
  logic [N-1:0]  num_q,   num_d;
  logic [W:0]    rem_q,   rem_d;
  logic [W-1:0]  acc_q,   acc_d;
  logic [W-1:0]  dsr_q,   dsr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          ovf_q,   ovf_d;
  logic          dz_q,    dz_d;

  logic          step_ge;
  logic [W:0]    step_rem;
  logic          k_low;

  fix_div_step #(.W(W)) u_step (
    .rem_i     (rem_q),
    .bit_i     (num_q[N-1]),
    .divisor_i (dsr_q),
    .ge_o      (step_ge),
    .rem_o     (step_rem)
  );

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    add_in0   = acc_q;
    add_in1   = '0;
    add_u     = '0;
    add_s_add = 1'b0;
    k_low     = (int'(cnt_q) < W);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          num_d = {dividend, {Bf{1'b0}}};
          rem_d = '0;
          dsr_d = divisor;
          cnt_d = CW'(N - 1);
          ovf_d = 1'b0;
          if (divisor == '0) begin
            acc_d   = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            acc_d   = '0;
            dz_d    = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        num_d = num_q << 1;
        if (step_ge) begin
          // Quotient bits above W cannot be held; they only mark overflow.
          if (k_low) begin
            add_u = W'(cnt_q);
            acc_d = add_out0;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ovf       = ovf_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

`ifdef FIX_DIV_SAT_EN
  assign quotient = ovf_q ? '1 : acc_q;
`else
  assign quotient = acc_q;
`endif

endmodule

// File: tb/tb_fix_div_seq.sv
// Directed bench for fix_div_seq with a behavioural model of the downstream adder.
module tb_fix_div_seq;
  import nlf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] dividend, divisor;
  logic [15:0] add_in0, add_in1, add_u, add_out0;
  logic        add_s_add;
  logic        out_valid, out_ready;
  logic [15:0] quotient;
  logic        ovf, div_zero;
  div_state_e  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

`ifdef FIX_DIV_SAT_EN
  localparam logic [15:0] OVF_Q = 16'hFFFF;
`else
  localparam logic [15:0] OVF_Q = 16'h0000;
`endif

  fix_div_seq #(.Bf(8), .FIX_POINT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .add_in0(add_in0), .add_in1(add_in1), .add_u(add_u), .add_s_add(add_s_add),
    .add_out0(add_out0), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .ovf(ovf), .div_zero(div_zero), .dbg_state(dbg_state)
  );

  // Adder stage: sets bit add_u of add_in0 (plus add_in1) when add_s_add is low.
  always_comb begin
    if (add_s_add) add_out0 = add_in0 - add_in1;
    else           add_out0 = add_in0 + add_in1 + (16'h0001 << add_u);
  end

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic exp_ovf, input logic exp_dz,
                         input int exp_lat, input logic [15:0] exp_req, input int hold);
    int cycles;
    logic [15:0] req_sum, prev_in0, prev_u, held_q, exp_val;
    logic prev_run;
    exp_q.push_back(q);
    @(negedge clk);
    dividend = a; divisor = b; in_valid = 1'b1;
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles   = 1;
    req_sum  = '0;
    prev_in0 = add_in0; prev_u = add_u; prev_run = (dbg_state == RUN);
    while (!out_valid && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (prev_run && add_in0 != prev_in0) req_sum = req_sum + (16'h0001 << prev_u);
      prev_in0 = add_in0; prev_u = add_u; prev_run = (dbg_state == RUN);
    end
    exp_val = exp_q.pop_front();
    check_eq({tag, "_latency"}, cycles, exp_lat);
    check_eq({tag, "_quotient"}, quotient, exp_val);
    check_eq({tag, "_ovf"}, ovf, exp_ovf);
    check_eq({tag, "_div_zero"}, div_zero, exp_dz);
    check_eq({tag, "_adder_reqs"}, req_sum, exp_req);
    held_q = quotient;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; dividend = 16'h0400; divisor = 16'h0100;
      @(posedge clk); #1;
      check_eq({tag, "_hold_valid"}, out_valid, 1'b1);
      check_eq({tag, "_hold_in_ready"}, in_ready, 1'b0);
      check_eq({tag, "_hold_quotient"}, quotient, held_q);
      check_eq({tag, "_hold_ovf"}, ovf, exp_ovf);
      check_eq({tag, "_hold_dz"}, div_zero, exp_dz);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_released"}, out_valid, 1'b0);
    check_eq({tag, "_back_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    int stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_quotient", quotient, 16'h0000);
    check_eq("rst_ovf", ovf, 1'b0);
    check_eq("rst_div_zero", div_zero, 1'b0);
    check_eq("rst_add_in0", add_in0, 16'h0000);
    check_eq("rst_add_in1", add_in1, 16'h0000);
    check_eq("rst_add_u", add_u, 16'h0000);
    check_eq("rst_add_s_add", add_s_add, 1'b0);
    @(negedge clk); rst = 1'b0;

    run_div("q1p5",   16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 25, 16'h0180, 0);
    run_div("third",  16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25, 16'h0055, 0);
    run_div("ovf",    16'h7F00, 16'h0001, OVF_Q,    1'b1, 1'b0, 25, 16'h0000, 0);
    run_div("dz",     16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1,  16'h0000, 0);
    run_div("ones",   16'hFFFF, 16'hFFFF, 16'h0100, 1'b0, 1'b0, 25, 16'h0100, 0);
    run_div("half",   16'h0001, 16'h0002, 16'h0080, 1'b0, 1'b0, 25, 16'h0080, 0);
    run_div("stall",  16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 25, 16'h0055, 5);

    // Abort an operation mid-run; nothing from it may surface afterwards.
    @(negedge clk);
    dividend = 16'h0300; divisor = 16'h0200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("abort_in_run", dbg_state, RUN);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_out_valid", out_valid, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    check_eq("abort_quotient", quotient, 16'h0000);
    @(negedge clk); rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check_eq("abort_stale_valid", stale, 0);
    run_div("post_rst", 16'h0200, 16'h0100, 16'h0200, 1'b0, 1'b0, 25, 16'h0200, 0);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fix_div_seq.md
FIX_DIV_SEQ -- requirements
Module: fix_div_seq

Interface
REQ-001 SHALL have parameter Bf, default 8, number of fractional bits.
REQ-002 SHALL have parameter FIX_POINT_WIDTH, default 16, operand and quotient width W.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have ports dividend and divisor, each input, W bits, unsigned fixed-point with Bf fractional bits.
REQ-008 SHALL have ports add_in0, add_in1 and add_u, each output, W bits, driving the downstream adder stage.
REQ-009 SHALL have port add_s_add  output  1  adder operand select.
REQ-010 SHALL have port add_out0  input  W  adder stage result.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port quotient  output  W  result.
REQ-014 SHALL have port ovf  output  1  quotient exceeded W bits.
REQ-015 SHALL have port div_zero  output  1  divisor was zero.

Function
REQ-016 SHALL compute quotient = floor((dividend << Bf) / divisor) by restoring long division over N = W+Bf numerator bits, MSB first.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; transitions: IDLE->RUN on in_valid&&in_ready with nonzero divisor; IDLE->DONE when divisor==0; RUN->DONE after exactly N RUN cycles; DONE->IDLE on out_ready.
REQ-018 SHALL assert in_ready only in IDLE and out_valid only in DONE.
REQ-019 SHALL, in each RUN cycle for bit k = N-1 down to 0, form r' = {r, numerator[k]} in a (W+1)-bit remainder register, and when r' >= divisor, store r' - divisor; otherwise store r'.
REQ-020 SHALL, when r' >= divisor and k < W, drive add_in0 = quotient accumulator, add_u = k and add_s_add = 0, and load add_out0 into the accumulator at the clock edge.
REQ-021 SHALL, when r' >= divisor and k >= W, set the sticky ovf flag and issue no adder request.
REQ-022 SHALL drive add_in1 = 0 at all times and add_in0 = accumulator with add_u = 0 when no request is issued; add_out0 SHALL be ignored in that case.
REQ-023 SHALL have a latency of N+1 cycles from the accept edge to out_valid for a nonzero divisor, and 1 cycle for a zero divisor.
REQ-024 SHALL, for a zero divisor, present quotient = all-ones with div_zero = 1 and ovf = 0.
REQ-025 SHALL hold quotient, ovf and div_zero stable in DONE until out_ready is high; in_valid during RUN or DONE SHALL be ignored, not queued.
REQ-026 SHALL clear the accumulator, remainder and flags on every accept.

Reset
REQ-027 SHALL, on rst, enter IDLE with in_ready=1, out_valid=0, quotient=0, ovf=0, div_zero=0, add_in0=0, add_u=0 and add_s_add=0.
REQ-028 SHALL, when rst is asserted mid-RUN or in DONE, abandon the operation and produce no out_valid for it.

Configuration
REQ-029 SHALL, with FIX_DIV_SAT_EN defined, output quotient = all-ones whenever ovf = 1.
REQ-030 SHALL, without FIX_DIV_SAT_EN, output the low W quotient bits (wrap) when ovf = 1; ovf SHALL be reported in both builds.

Structure
REQ-031 SHALL take the FSM state enum and the derived constant N = W+Bf from a shared package nlf_pkg.
REQ-032 SHALL place the compare/subtract of one restoring step in the sub-module fix_div_step.

Verification
REQ-033 SHALL test 0x0300 / 0x0200 (Q8.8): expect quotient 0x0180, ovf 0, out_valid on cycle 25 after accept.
REQ-034 SHALL test 0x0100 / 0x0300: expect quotient 0x0055, with 0x0055 equal to the accumulated adder requests.
REQ-035 SHALL test 0x7F00 / 0x0001: expect ovf 1; quotient 0xFFFF with FIX_DIV_SAT_EN, 0x0000 without.
REQ-036 SHALL test 0x1234 / 0x0000: expect div_zero 1, quotient 0xFFFF, out_valid one cycle after accept.
REQ-037 SHALL test rst asserted at RUN cycle 10, then 0x0200 / 0x0100: expect no stale out_valid and quotient 0x0200.
REQ-038 SHALL test out_ready held low for 5 cycles in DONE: expect outputs stable and in_ready = 0 throughout.
